// File: rtl/decoder2to4_pulse.sv
// Registered 2-to-4 one-hot decoder: each accepted code drives its Q line for PULSE_W cycles, then strobes done.
// Define DEC_GAP_EN to add a one-cycle GAP state (Q=0, done=1, ready=0) after each normal completion.
module decoder2to4_pulse #(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] D,
  input  logic       EN,
  input  logic       valid,
  output logic       ready,
  output logic [3:0] Q,
  output logic       busy,
  output logic       done
);

`ifdef DEC_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1} state_t;
`endif

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_W - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Acceptance only from IDLE, and only while enabled.
  assign ready = (state == IDLE) && EN;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      Q     <= 4'b0000;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid && ready) begin
            Q     <= 4'b0001 << D;
            cnt   <= CNT_LOAD;
            busy  <= 1'b1;
            state <= PULSE;
          end
        end
        PULSE: begin
          // Dropping EN aborts without a completion strobe.
          if (!EN) begin
            Q     <= 4'b0000;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == '0) begin
            Q    <= 4'b0000;
            busy <= 1'b0;
            done <= 1'b1;
`ifdef DEC_GAP_EN
            state <= GAP;
`else
            state <= IDLE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef DEC_GAP_EN
        GAP: begin
          state <= IDLE;
        end
`endif
        default: begin
          state <= IDLE;
          Q     <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder2to4_pulse.sv
// Bench for decoder2to4_pulse: PULSE_W=4 and PULSE_W=1 instances share stimulus and are checked
// every cycle against a timeline model (cycles of Q remaining, pending done, gap cycle).
module tb_decoder2to4_pulse;

  logic       clk = 1'b0;
  logic       rst_n, EN, valid;
  logic [1:0] D;
  logic       r0, b0, d0, r1, b1, d1;
  logic [3:0] q0, q1;

  always #5 clk = ~clk;

  decoder2to4_pulse #(.PULSE_W(4), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .D(D), .EN(EN), .valid(valid),
    .ready(r0), .Q(q0), .busy(b0), .done(d0)
  );

  decoder2to4_pulse #(.PULSE_W(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .D(D), .EN(EN), .valid(valid),
    .ready(r1), .Q(q1), .busy(b1), .done(d1)
  );

`ifdef DEC_GAP_EN
  localparam bit HAS_GAP = 1'b1;
`else
  localparam bit HAS_GAP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Model: rem = Q cycles still to show (0 when not pulsing), dn = done this cycle, gp = in gap cycle.
  int rem  [2];
  int code [2];
  bit dn   [2];
  bit gp   [2];

  function automatic int pw(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [3:0] exp_q(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return (rem[i] > 0) ? (one << code[i]) : 4'b0000;
  endfunction

  function automatic logic exp_ready(input int i);
    return (rem[i] == 0) && !gp[i] && EN;
  endfunction

  task automatic model_step(input int i);
    if (!rst_n) begin
      rem[i] = 0; dn[i] = 1'b0; gp[i] = 1'b0;
    end else if (rem[i] > 0) begin
      if (!EN) begin
        rem[i] = 0; dn[i] = 1'b0;
      end else if (rem[i] == 1) begin
        rem[i] = 0; dn[i] = 1'b1; gp[i] = HAS_GAP;
      end else begin
        rem[i] = rem[i] - 1; dn[i] = 1'b0;
      end
    end else if (gp[i]) begin
      gp[i] = 1'b0; dn[i] = 1'b0;
    end else begin
      dn[i] = 1'b0;
      if (valid && EN) begin
        rem[i] = pw(i); code[i] = int'(D);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  // One clock: drive inputs, check ready before the edge, advance model, check registered outputs.
  task automatic cyc(input logic r, input logic e, input logic v, input logic [1:0] d);
    rst_n = r; EN = e; valid = v; D = d;
    #2;
    if (started) begin
      chk("ready_w4", {3'b000, r0}, {3'b000, exp_ready(0)});
      chk("ready_w1", {3'b000, r1}, {3'b000, exp_ready(1)});
    end
    @(posedge clk);
    model_step(0);
    model_step(1);
    started = 1'b1;
    #1;
    chk("q_w4",    q0,                exp_q(0));
    chk("busy_w4", {3'b000, b0},      {3'b000, rem[0] > 0});
    chk("done_w4", {3'b000, d0},      {3'b000, dn[0]});
    chk("q_w1",    q1,                exp_q(1));
    chk("busy_w1", {3'b000, b1},      {3'b000, rem[1] > 0});
    chk("done_w1", {3'b000, d1},      {3'b000, dn[1]});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b1, 1'b0, 2'b00);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0; code[i] = 0; dn[i] = 1'b0; gp[i] = 1'b0;
    end
    rst_n = 1'b0; EN = 1'b1; valid = 1'b1; D = 2'b00;
    @(negedge clk);

    // Reset held with a valid offered: nothing accepted.
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1, 2'b00);

    // Single code D=10.
    cyc(1'b1, 1'b1, 1'b1, 2'b10);
    idle(8);

    // All codes back-to-back, valid held, each code held until the W4 instance takes it.
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < (HAS_GAP ? 6 : 5); k++) cyc(1'b1, 1'b1, 1'b1, 2'(c));
    idle(8);

    // Abort: accept D=11, drop EN on the second Q cycle.
    cyc(1'b1, 1'b1, 1'b1, 2'b11);
    cyc(1'b1, 1'b1, 1'b0, 2'b11);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 2'b11);
    idle(3);

    // Blocked source: valid held with EN low, then EN returns.
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b1, 2'b01);
    cyc(1'b1, 1'b1, 1'b1, 2'b01);
    idle(7);

    // Minimum width back-to-back, then reset during a Q cycle.
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 1'b1, 2'b10);
    cyc(1'b1, 1'b1, 1'b1, 2'b00);
    cyc(1'b1, 1'b1, 1'b0, 2'b00);
    cyc(1'b0, 1'b1, 1'b0, 2'b00);
    idle(4);

    // Randomized traffic with occasional EN drops and resets.
    for (int k = 0; k < 400; k++)
      cyc(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 9) != 0),
          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
